// File: rtl/tree_node_walker.sv
// tree_node_walker: walks one decision tree per start, one node record per
// ISSUE/WAIT/EVAL round trip to a fixed-latency node memory, and reports the
// reached leaf class (or a depth error) as a one-cycle result.
module tree_node_walker #(
  parameter int ADDR_W    = 13,
  parameter int FEAT_W    = 5,
  parameter int DATA_W    = 16,
  parameter int CLASS_W   = 4,
  parameter int MEM_LAT   = 2,
  parameter int MAX_DEPTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  tree_base,
  output logic               busy,
  output logic [ADDR_W-1:0]  node_addr,
  output logic               node_rd_en,
  input  logic               node_is_leaf,
  input  logic [FEAT_W-1:0]  node_feat,
  input  logic [DATA_W-1:0]  node_thr,
  input  logic [ADDR_W-1:0]  node_left,
  input  logic [ADDR_W-1:0]  node_right,
  input  logic [CLASS_W-1:0] node_class,
  output logic [FEAT_W-1:0]  feat_idx,
  input  logic [DATA_W-1:0]  feat_val,
  output logic [CLASS_W-1:0] result_class,
  output logic               result_vld,
  output logic               depth_err
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int DEP_W = $clog2(MAX_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [DEP_W-1:0]   depth_q, depth_d;
  logic               leaf_q, leaf_d;
  logic [DATA_W-1:0]  thr_q, thr_d;
  logic [ADDR_W-1:0]  left_q, left_d;
  logic [ADDR_W-1:0]  right_q, right_d;
  logic [CLASS_W-1:0] ncls_q, ncls_d;
  logic [FEAT_W-1:0]  feat_q, feat_d;
  logic [CLASS_W-1:0] rcls_q, rcls_d;
  logic               err_q, err_d;
  logic               go_left;

  // Ties go left: signed feature value at or below the threshold.
  assign go_left = $signed(feat_val) <= $signed(thr_q);

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      depth_q <= '0;
      leaf_q  <= 1'b0;
      thr_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      ncls_q  <= '0;
      feat_q  <= '0;
      rcls_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      depth_q <= depth_d;
      leaf_q  <= leaf_d;
      thr_q   <= thr_d;
      left_q  <= left_d;
      right_q <= right_d;
      ncls_q  <= ncls_d;
      feat_q  <= feat_d;
      rcls_q  <= rcls_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; node record captured in the last WAIT cycle.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    depth_d = depth_q;
    leaf_d  = leaf_q;
    thr_d   = thr_q;
    left_d  = left_q;
    right_d = right_q;
    ncls_d  = ncls_q;
    feat_d  = feat_q;
    rcls_d  = rcls_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = tree_base;
          addr_d  = tree_base;
          depth_d = '0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_W'(MEM_LAT - 1)) begin
          leaf_d  = node_is_leaf;
          thr_d   = node_thr;
          left_d  = node_left;
          right_d = node_right;
          ncls_d  = node_class;
          // feat_idx only moves for internal nodes so it holds otherwise.
          if (!node_is_leaf) feat_d = node_feat;
          state_d = S_EVAL;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_EVAL: begin
        if (leaf_q) begin
          rcls_d  = ncls_q;
          state_d = S_DONE;
        end else if (depth_q == DEP_W'(MAX_DEPTH - 1)) begin
          rcls_d  = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = base_q + (go_left ? left_q : right_q);
          depth_d = depth_q + DEP_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign node_rd_en   = (state_q == S_ISSUE);
  assign result_vld   = (state_q == S_DONE);
  assign node_addr    = addr_q;
  assign feat_idx     = feat_q;
  assign result_class = rcls_q;
  assign depth_err    = err_q;

endmodule

// File: tb/tb_tree_node_walker.sv
// Directed bench for tree_node_walker with a fixed-latency node memory model.
module tb_tree_node_walker;

  localparam int ADDR_W = 13;
  localparam int FEAT_W = 5;
  localparam int DATA_W = 16;
  localparam int CLASS_W = 4;
  localparam int MEM_LAT = 2;
  localparam int MAX_DEPTH = 4;
  localparam int LIMIT = 60;

  typedef struct packed {
    logic               leaf;
    logic [FEAT_W-1:0]  feat;
    logic [DATA_W-1:0]  thr;
    logic [ADDR_W-1:0]  l;
    logic [ADDR_W-1:0]  r;
    logic [CLASS_W-1:0] cls;
  } node_t;

  localparam node_t JUNK = '{leaf: 1'b0, feat: 5'd31, thr: 16'h7FFF,
                             l: 13'h1555, r: 13'h0AAA, cls: 4'hF};

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [ADDR_W-1:0]  tree_base;
  logic               busy;
  logic [ADDR_W-1:0]  node_addr;
  logic               node_rd_en;
  logic [FEAT_W-1:0]  feat_idx;
  logic [DATA_W-1:0]  feat_val;
  logic [CLASS_W-1:0] result_class;
  logic               result_vld;
  logic               depth_err;

  node_t              mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0]  feats [0:(1<<FEAT_W)-1];
  logic [ADDR_W-1:0]  pa [MEM_LAT];
  logic               pv [MEM_LAT];
  node_t              rec;
  logic [ADDR_W-1:0]  rd_q [$];

  int total = 0;
  int bad = 0;
  int lat;

  tree_node_walker #(
    .ADDR_W(ADDR_W), .FEAT_W(FEAT_W), .DATA_W(DATA_W), .CLASS_W(CLASS_W),
    .MEM_LAT(MEM_LAT), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tree_base(tree_base),
    .busy(busy), .node_addr(node_addr), .node_rd_en(node_rd_en),
    .node_is_leaf(rec.leaf), .node_feat(rec.feat), .node_thr(rec.thr),
    .node_left(rec.l), .node_right(rec.r), .node_class(rec.cls),
    .feat_idx(feat_idx), .feat_val(feat_val),
    .result_class(result_class), .result_vld(result_vld), .depth_err(depth_err)
  );

  always #5 clk = ~clk;

  // Memory model: record appears MEM_LAT cycles after the read strobe.
  always @(posedge clk) begin
    pa[0] <= node_addr;
    pv[0] <= node_rd_en;
    for (int i = 1; i < MEM_LAT; i++) begin
      pa[i] <= pa[i-1];
      pv[i] <= pv[i-1];
    end
    if (node_rd_en) rd_q.push_back(node_addr);
  end

  always_comb rec = pv[MEM_LAT-1] ? mem[pa[MEM_LAT-1]] : JUNK;
  assign feat_val = feats[feat_idx];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_addr"}, 32'(node_addr), 0);
    check({pfx, "_rden"}, 32'(node_rd_en), 0);
    check({pfx, "_fidx"}, 32'(feat_idx), 0);
    check({pfx, "_cls"}, 32'(result_class), 0);
    check({pfx, "_vld"}, 32'(result_vld), 0);
    check({pfx, "_err"}, 32'(depth_err), 0);
  endtask

  // Start a traversal at the next negedge; optional stray start pulses at
  // cycle offsets p1/p2. Returns cycles from acceptance to result_vld.
  task automatic run(input logic [ADDR_W-1:0] base, input int p1, input int p2,
                     output int l);
    @(negedge clk);
    check("pre_busy", 32'(busy), 0);
    check("pre_vld", 32'(result_vld), 0);
    start = 1'b1;
    tree_base = base;
    rd_q.delete();
    l = -1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (k == p1 || k == p2) begin
        start = 1'b1;
        tree_base = 13'h0100;
      end else begin
        start = 1'b0;
      end
      if (k == 1) begin
        check("busy_s1", 32'(busy), 1);
        check("err_clr", 32'(depth_err), 0);
      end
      if (result_vld) begin
        l = k;
        break;
      end
    end
    start = 1'b0;
    if (l < 0) check("timeout", 32'(LIMIT), 0);
  endtask

  task automatic check_reads(input string tag, input int n,
                             input logic [ADDR_W-1:0] a0,
                             input logic [ADDR_W-1:0] a1,
                             input logic [ADDR_W-1:0] a2);
    logic [ADDR_W-1:0] exp_a [3];
    exp_a[0] = a0; exp_a[1] = a1; exp_a[2] = a2;
    check({tag, "_nrd"}, 32'(rd_q.size()), 32'(n));
    for (int i = 0; i < n && i < 3 && i < rd_q.size(); i++)
      check({tag, "_rdaddr"}, 32'(rd_q[i]), 32'(exp_a[i]));
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    for (int i = 0; i < (1 << FEAT_W); i++) feats[i] = '0;
    for (int i = 0; i < MEM_LAT; i++) begin pa[i] = '0; pv[i] = 1'b0; end

    // Root leaf tree.
    mem[13'h0100] = '{leaf: 1'b1, feat: 5'd0, thr: 16'h0, l: 13'h0, r: 13'h0, cls: 4'd7};
    // Three-level tree: tie goes left, then -4 > -5 goes right.
    mem[13'h0200] = '{leaf: 1'b0, feat: 5'd3, thr: 16'd10, l: 13'h010, r: 13'h020, cls: 4'd0};
    mem[13'h0210] = '{leaf: 1'b0, feat: 5'd5, thr: 16'hFFFB, l: 13'h030, r: 13'h040, cls: 4'd0};
    mem[13'h0220] = '{leaf: 1'b1, feat: 5'd0, thr: 16'h0, l: 13'h0, r: 13'h0, cls: 4'd11};
    mem[13'h0230] = '{leaf: 1'b1, feat: 5'd0, thr: 16'h0, l: 13'h0, r: 13'h0, cls: 4'd12};
    mem[13'h0240] = '{leaf: 1'b1, feat: 5'd0, thr: 16'h0, l: 13'h0, r: 13'h0, cls: 4'd2};
    feats[3] = 16'd10;
    feats[5] = 16'hFFFC;
    // Wrapping tree: 5 > 0 goes right, 0x1FF0 + 0x20 wraps to 0x0010.
    mem[13'h1FF0] = '{leaf: 1'b0, feat: 5'd1, thr: 16'd0, l: 13'h004, r: 13'h020, cls: 4'd0};
    mem[13'h0010] = '{leaf: 1'b1, feat: 5'd0, thr: 16'h0, l: 13'h0, r: 13'h0, cls: 4'd9};
    mem[13'h1FF4] = '{leaf: 1'b1, feat: 5'd0, thr: 16'h0, l: 13'h0, r: 13'h0, cls: 4'd1};
    feats[1] = 16'd5;
    // Self-looping internal node.
    mem[13'h0400] = '{leaf: 1'b0, feat: 5'd0, thr: 16'd0, l: 13'h000, r: 13'h000, cls: 4'd6};
    feats[0] = 16'd0;

    rst_n = 1'b0;
    start = 1'b0;
    tree_base = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("rst");
    rst_n = 1'b1;

    // Root leaf.
    run(13'h0100, 0, 0, lat);
    check("leaf_lat", 32'(lat), 5);
    check("leaf_cls", 32'(result_class), 7);
    check("leaf_err", 32'(depth_err), 0);
    check_reads("leaf", 1, 13'h0100, 13'h0, 13'h0);

    // Three-level path.
    run(13'h0200, 0, 0, lat);
    check("path_lat", 32'(lat), 13);
    check("path_cls", 32'(result_class), 2);
    check("path_err", 32'(depth_err), 0);
    check("path_fidx", 32'(feat_idx), 5);
    check_reads("path", 3, 13'h0200, 13'h0210, 13'h0240);

    // Address wrap.
    run(13'h1FF0, 0, 0, lat);
    check("wrap_lat", 32'(lat), 9);
    check("wrap_cls", 32'(result_class), 9);
    check_reads("wrap", 2, 13'h1FF0, 13'h0010, 13'h0);

    // Depth limit.
    run(13'h0400, 0, 0, lat);
    check("depth_lat", 32'(lat), 17);
    check("depth_err", 32'(depth_err), 1);
    check("depth_cls", 32'(result_class), 0);
    check("depth_nrd", 32'(rd_q.size()), 4);
    for (int i = 0; i < rd_q.size(); i++)
      check("depth_rdaddr", 32'(rd_q[i]), 32'h0400);
    @(negedge clk);
    check("err_hold", 32'(depth_err), 1);

    // Stray starts during WAIT and EVAL, then a back-to-back start.
    run(13'h0200, 3, 4, lat);
    check("busy_lat", 32'(lat), 13);
    check("busy_cls", 32'(result_class), 2);
    check_reads("busy", 3, 13'h0200, 13'h0210, 13'h0240);
    run(13'h0100, 0, 0, lat);
    check("b2b_lat", 32'(lat), 5);
    check("b2b_cls", 32'(result_class), 7);

    // Reset during WAIT.
    @(negedge clk);
    start = 1'b1;
    tree_base = 13'h0200;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("mrst");
    rst_n = 1'b1;
    begin
      int vld_seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (result_vld || busy) vld_seen++;
      end
      check("mrst_quiet", 32'(vld_seen), 0);
    end
    run(13'h0100, 0, 0, lat);
    check("mrst_lat", 32'(lat), 5);
    check("mrst_cls", 32'(result_class), 7);
    check("mrst_err", 32'(depth_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
